// File: rtl/conv_kxk_mc.sv
// Multi-channel KxK convolution engine: serial weight/bias load, per-channel window
// dot products accumulated into one pixel, bias add, optional ReLU, valid/ready output.

module conv_kxk_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 3,
    parameter int CH_IN      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int RELU_EN    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              keep_weights,
    output logic                              done,
    input  logic                              weight_valid_in,
    output logic                              weight_ready_out,
    input  logic [DATA_WIDTH-1:0]             weight_data,
    input  logic                              input_valid_in,
    output logic                              input_ready_out,
    input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0] window_data,
    output logic                              out_valid_out,
    input  logic                              out_ready_in,
    output logic [ACC_WIDTH-1:0]              out_data
);

    localparam int KK   = KSIZE * KSIZE;
    localparam int NW   = CH_IN * KK;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int WI_W = $clog2(NW + 1);
    localparam int WK_W = (KK > 1) ? $clog2(KK) : 1;
    localparam int WC_W = (CH_IN > 1) ? $clog2(CH_IN) : 1;

    localparam logic [WI_W-1:0] W_LAST = WI_W'(NW);
    localparam logic [WI_W-1:0] WI_ONE = WI_W'(1);
    localparam logic [WK_W-1:0] K_LAST = WK_W'(KK - 1);
    localparam logic [WK_W-1:0] WK_ONE = WK_W'(1);
    localparam logic [WC_W-1:0] C_LAST = WC_W'(CH_IN - 1);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_IN     = 3'd2,
        ST_BIAS   = 3'd3,
        ST_OUT    = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    state_t                                    state_r;
    logic [CH_IN-1:0][KK-1:0][DATA_WIDTH-1:0] w_r;
    logic [DATA_WIDTH-1:0]                     bias_r;
    logic                                      w_loaded_r;
    logic [WI_W-1:0]                           w_idx_r;
    logic [WK_W-1:0]                           wk_r;
    logic [WC_W-1:0]                           wch_r;
    logic [WC_W-1:0]                           ch_cnt_r;
    logic [ACC_WIDTH-1:0]                      acc_r;

    logic signed [PW-1:0]                      px_s;
    logic signed [PW-1:0]                      wx_s;
    logic signed [PW-1:0]                      prod_s;
    logic [ACC_WIDTH-1:0]                      dot_s;
    logic [ACC_WIDTH-1:0]                      sum_s;
    logic [ACC_WIDTH-1:0]                      res_s;

    // Dot product of the presented window with the weights of the current channel
    always_comb begin
        dot_s  = '0;
        px_s   = '0;
        wx_s   = '0;
        prod_s = '0;
        for (int k = 0; k < KK; k++) begin
            px_s   = {{DATA_WIDTH{window_data[k*DATA_WIDTH+DATA_WIDTH-1]}},
                      window_data[k*DATA_WIDTH +: DATA_WIDTH]};
            wx_s   = {{DATA_WIDTH{w_r[ch_cnt_r][WK_W'(k)][DATA_WIDTH-1]}},
                      w_r[ch_cnt_r][WK_W'(k)]};
            prod_s = px_s * wx_s;
            dot_s  = dot_s + {{(ACC_WIDTH-PW){prod_s[PW-1]}}, prod_s};
        end
    end

    // Bias add and optional negative clamp
    always_comb begin
        sum_s = acc_r + {{(ACC_WIDTH-DATA_WIDTH){bias_r[DATA_WIDTH-1]}}, bias_r};
        if ((RELU_EN != 0) && sum_s[ACC_WIDTH-1]) begin
            res_s = '0;
        end else begin
            res_s = sum_s;
        end
    end

    // Job sequencer with registered handshake outputs and weight storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            w_r              <= '0;
            bias_r           <= '0;
            w_loaded_r       <= 1'b0;
            w_idx_r          <= '0;
            wk_r             <= '0;
            wch_r            <= '0;
            ch_cnt_r         <= '0;
            acc_r            <= '0;
            done             <= 1'b0;
            weight_ready_out <= 1'b0;
            input_ready_out  <= 1'b0;
            out_valid_out    <= 1'b0;
            out_data         <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r    <= '0;
                        ch_cnt_r <= '0;
                        if (keep_weights && w_loaded_r) begin
                            input_ready_out <= 1'b1;
                            state_r         <= ST_IN;
                        end else begin
                            w_loaded_r       <= 1'b0;
                            w_idx_r          <= '0;
                            wk_r             <= '0;
                            wch_r            <= '0;
                            weight_ready_out <= 1'b1;
                            state_r          <= ST_LOAD_W;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (weight_valid_in && weight_ready_out) begin
                        if (w_idx_r == W_LAST) begin
                            bias_r           <= weight_data;
                            w_loaded_r       <= 1'b1;
                            acc_r            <= '0;
                            ch_cnt_r         <= '0;
                            weight_ready_out <= 1'b0;
                            input_ready_out  <= 1'b1;
                            state_r          <= ST_IN;
                        end else begin
                            w_r[wch_r][wk_r] <= weight_data;
                            w_idx_r          <= w_idx_r + WI_ONE;
                            if (wk_r == K_LAST) begin
                                wk_r  <= '0;
                                wch_r <= wch_r + WC_ONE;
                            end else begin
                                wk_r <= wk_r + WK_ONE;
                            end
                        end
                    end
                end
                ST_IN: begin
                    if (input_valid_in && input_ready_out) begin
                        acc_r <= acc_r + dot_s;
                        if (ch_cnt_r == C_LAST) begin
                            ch_cnt_r        <= '0;
                            input_ready_out <= 1'b0;
                            state_r         <= ST_BIAS;
                        end else begin
                            ch_cnt_r <= ch_cnt_r + WC_ONE;
                        end
                    end
                end
                ST_BIAS: begin
                    out_data      <= res_s;
                    out_valid_out <= 1'b1;
                    state_r       <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready_in) begin
                        out_valid_out <= 1'b0;
                        done          <= 1'b1;
                        state_r       <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done             <= 1'b0;
                    weight_ready_out <= 1'b0;
                    input_ready_out  <= 1'b0;
                    out_valid_out    <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kxk_mc.sv
// Scoreboard bench for conv_kxk_mc: two instances (ReLU on / off) share stimulus;
// expected raw results are queued at job issue and popped on each output handshake.

module tb_conv_kxk_mc;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int KK = K * K;
    localparam int CH = 2;
    localparam int AW = 32;
    localparam int NW = CH * KK;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic keep_weights = 1'b0;
    logic weight_valid_in = 1'b0;
    logic [DW-1:0] weight_data = '0;
    logic input_valid_in = 1'b0;
    logic [KK*DW-1:0] window_data = '0;
    logic out_ready_in = 1'b1;

    logic done_a, wr_a, ir_a, ov_a;
    logic done_b, wr_b, ir_b, ov_b;
    logic [AW-1:0] od_a, od_b;

    always #5 clk = ~clk;

    conv_kxk_mc #(.DATA_WIDTH(DW), .KSIZE(K), .CH_IN(CH), .ACC_WIDTH(AW), .RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .keep_weights(keep_weights), .done(done_a),
        .weight_valid_in(weight_valid_in), .weight_ready_out(wr_a), .weight_data(weight_data),
        .input_valid_in(input_valid_in), .input_ready_out(ir_a), .window_data(window_data),
        .out_valid_out(ov_a), .out_ready_in(out_ready_in), .out_data(od_a)
    );

    conv_kxk_mc #(.DATA_WIDTH(DW), .KSIZE(K), .CH_IN(CH), .ACC_WIDTH(AW), .RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .keep_weights(keep_weights), .done(done_b),
        .weight_valid_in(weight_valid_in), .weight_ready_out(wr_b), .weight_data(weight_data),
        .input_valid_in(input_valid_in), .input_ready_out(ir_b), .window_data(window_data),
        .out_valid_out(ov_b), .out_ready_in(out_ready_in), .out_data(od_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int valid_cyc = 0;
    int cyc_start = 0;
    logic ov_prev = 1'b0;
    bit model_loaded = 1'b0;
    logic signed [AW-1:0] q_raw[$];
    logic [DW-1:0] wts[NW+1];
    logic [KK*DW-1:0] wins[CH];

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%h), want %0d (0x%h) at t=%0t",
                     name, $signed(act), act, $signed(exp), exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic signed [AW-1:0] e;
        if (!rst) begin
            if (done_a) done_cnt <= done_cnt + 1;
            if (wr_a) wr_cnt <= wr_cnt + 1;
            if (ov_a && !ov_prev) valid_cyc <= cyc;
            ov_prev <= ov_a;
            if (ov_a && out_ready_in) begin
                if (q_raw.size() == 0) begin
                    check("spurious_out", AW'(ov_a), AW'(0));
                end else begin
                    e = q_raw.pop_front();
                    check("out_raw", od_b, e);
                    check("out_relu", od_a, (e < 0) ? '0 : e);
                    check("out_valid_b", AW'(ov_b), AW'(1));
                end
            end
        end
    end

    function automatic int gap(input int m);
        return (m == 0) ? 0 : int'($urandom_range(m));
    endfunction

    function automatic logic [KK*DW-1:0] fill_win(input int v);
        logic [KK*DW-1:0] w;
        for (int k = 0; k < KK; k++) w[k*DW +: DW] = DW'(v);
        return w;
    endfunction

    task automatic set_weights(input int v, input int b);
        for (int i = 0; i < NW; i++) wts[i] = DW'(v);
        wts[NW] = DW'(b);
    endtask

    task automatic send_weight(input logic [DW-1:0] d, input int g);
        int n;
        weight_valid_in = 1'b0;
        repeat (g) @(posedge clk);
        if (g > 0) #1;
        weight_valid_in = 1'b1;
        weight_data = d;
        n = 0;
        @(negedge clk);
        while (!wr_a && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("weight_ready_timeout", AW'(wr_a), AW'(1));
        @(posedge clk); #1;
        weight_valid_in = 1'b0;
    endtask

    task automatic send_window(input logic [KK*DW-1:0] d, input int g);
        int n;
        input_valid_in = 1'b0;
        repeat (g) @(posedge clk);
        if (g > 0) #1;
        input_valid_in = 1'b1;
        window_data = d;
        n = 0;
        @(negedge clk);
        while (!ir_a && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("input_ready_timeout", AW'(ir_a), AW'(1));
        @(posedge clk); #1;
        input_valid_in = 1'b0;
    endtask

    task automatic do_start(input bit keep);
        start = 1'b1;
        keep_weights = keep;
        @(posedge clk); #1;
        start = 1'b0;
        keep_weights = 1'b0;
        cyc_start = cyc;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        start = 1'b0;
        weight_valid_in = 1'b0;
        input_valid_in = 1'b0;
        #2;
        check({tag, "_rst_ctl"}, AW'({wr_a, ir_a, ov_a, done_a, wr_b, ir_b, ov_b, done_b}), AW'(0));
        check({tag, "_rst_data_a"}, od_a, '0);
        check({tag, "_rst_data_b"}, od_b, '0);
        model_loaded = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        check({tag, "_post_rst_idle"}, AW'({wr_a, ir_a, ov_a, done_a}), AW'(0));
    endtask

    task automatic run_job(input string tag, input bit keep, input logic signed [AW-1:0] exp_raw,
                           input int maxgap, input bit stall, input bit poke);
        bit load_exp;
        int d0, w0, n;
        load_exp = !(keep && model_loaded);
        d0 = done_cnt;
        w0 = wr_cnt;
        out_ready_in = !stall;
        do_start(keep);
        if (load_exp) begin
            for (int i = 0; i <= NW; i++) send_weight(wts[i], gap(maxgap));
            model_loaded = 1'b1;
        end
        q_raw.push_back(exp_raw);
        for (int c = 0; c < CH; c++) begin
            if (poke && c == 1) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_window(wins[c], gap(maxgap));
        end
        if (stall) begin
            n = 0;
            @(negedge clk);
            while (!ov_b && n < 20) begin @(negedge clk); n++; end
            for (int i = 0; i < 5; i++) begin
                check({tag, "_stall_valid"}, AW'(ov_b), AW'(1));
                check({tag, "_stall_data"}, od_b, exp_raw);
                check({tag, "_stall_done"}, AW'(done_cnt - d0), AW'(0));
                start = poke && (i == 2);
                @(negedge clk);
            end
            start = 1'b0;
            @(posedge clk); #1;
            out_ready_in = 1'b1;
        end
        n = 0;
        while (done_cnt == d0 && n < 40) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, AW'(done_cnt - d0), AW'(1));
        if (load_exp) begin
            check({tag, "_loaded"}, AW'((wr_cnt - w0) >= NW + 1), AW'(1));
        end else begin
            check({tag, "_no_reload"}, AW'(wr_cnt - w0), AW'(0));
        end
        if (!load_exp && maxgap == 0 && !poke) begin
            check({tag, "_latency"}, AW'(valid_cyc - cyc_start + 1), AW'(CH + 2));
        end
        check({tag, "_idle"}, AW'({wr_a, ir_a, ov_a, done_a, wr_b, ir_b, ov_b, done_b}), AW'(0));
        check({tag, "_hold_data"}, od_b, exp_raw);
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        do_reset("init");

        set_weights(1, 0);
        wins[0] = fill_win(2);
        wins[1] = fill_win(2);
        run_job("basic", 1'b0, 36, 0, 1'b0, 1'b0);

        set_weights(-1, 3);
        wins[0] = fill_win(5);
        wins[1] = fill_win(5);
        run_job("relu", 1'b0, -87, 0, 1'b0, 1'b0);

        set_weights(1, 0);
        wins[0] = fill_win(1);
        wins[1] = fill_win(1);
        run_job("reuse_load", 1'b0, 18, 0, 1'b0, 1'b0);
        run_job("reuse_keep", 1'b1, 18, 0, 1'b0, 1'b0);

        // ch0 weights 1..9 against window 0..8 -> 240; ch1 weights -1..-9 against 3s -> -135; bias 7
        for (int k = 0; k < KK; k++) begin
            wts[k] = DW'(k + 1);
            wts[KK + k] = DW'(-(k + 1));
            wins[0][k*DW +: DW] = DW'(k);
        end
        wts[NW] = DW'(7);
        wins[1] = fill_win(3);
        run_job("varied", 1'b0, 112, 0, 1'b0, 1'b0);
        run_job("gaps_load", 1'b0, 112, 3, 1'b0, 1'b0);
        run_job("gaps_keep", 1'b1, 112, 3, 1'b0, 1'b0);
        run_job("stall_poke", 1'b1, 112, 0, 1'b1, 1'b1);

        do_reset("rst_keep");
        run_job("keep_after_rst", 1'b1, 112, 0, 1'b0, 1'b0);

        do_start(1'b0);
        for (int i = 0; i < 7; i++) send_weight(wts[i], 0);
        do_reset("mid_load");
        run_job("after_mid_load", 1'b1, 112, 0, 1'b0, 1'b0);

        do_start(1'b1);
        send_window(wins[0], 0);
        do_reset("mid_window");
        run_job("after_mid_window", 1'b1, 112, 0, 1'b0, 1'b0);

        check("queue_drained", AW'(q_raw.size()), AW'(0));
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_kxk_mc.md
# conv_kxk_mc

Parametrised multi-channel K×K convolution engine. It is the next generation of the single-channel 3×3 conv unit.
- Loads a full K×K×CH_IN signed weight set plus one bias over a serial valid/ready port.
- Accepts one flattened K×K window per input channel and accumulates all channel dot products into one output pixel.
- Applies bias and optional ReLU, then presents the result on a valid/ready output port.
- Sits between the line-buffer/window generator and the feature-map writer. Weights can be kept across jobs, so they are loaded once per output map.

## Interface
- DATA_WIDTH, 8, signed width of pixels, weights and bias
- KSIZE, 3, kernel edge length (window = KSIZE*KSIZE elements)
- CH_IN, 4, input channels accumulated per output pixel
- ACC_WIDTH, 32, accumulator/output width; must be ≥ 2*DATA_WIDTH + clog2(KSIZE*KSIZE*CH_IN) + 1
- RELU_EN, 1, 1 = clamp negative results to 0

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- keep_weights  in  1  sampled with start; 1 = reuse stored weights if a set is loaded
- done  out  1  one-cycle pulse at job end
- weight_valid_in  in  1  weight beat valid
- weight_ready_out  out  1  high while loading weights
- weight_data  in  DATA_WIDTH  signed weight/bias beat
- input_valid_in  in  1  window beat valid
- input_ready_out  out  1  high while accepting windows
- window_data  in  KSIZE*KSIZE*DATA_WIDTH  row-major window; element (r,c) at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH]
- out_valid_out  out  1  result valid
- out_ready_in  in  1  downstream ready
- out_data  out  ACC_WIDTH  signed result

## Operation
- **States:** IDLE, LOAD_W, IN, BIAS, OUT, FIN.
- **IDLE:**
  - On start with keep_weights=1 and w_loaded=1, go to IN.
  - On any other start, clear w_loaded and go to LOAD_W.
  - start is ignored outside IDLE.
- **LOAD_W:**
  - weight_ready_out=1. Each valid&ready beat is stored at w_idx, then w_idx increments.
  - Order is channel-major, then row-major within the window: index ch*K*K + r*K + c. Beat CH_IN*K*K+1 (the last one) is the bias.
  - After the bias beat: set w_loaded=1, clear acc and ch_cnt, go to IN.
- **IN:**
  - input_ready_out=1. Each accepted beat computes the signed dot product of window_data with channel ch_cnt's weights.
  - Products are 2*DATA_WIDTH wide and sign-extended to ACC_WIDTH.
  - At the accepting edge, acc += dot and ch_cnt increments.
  - After beat CH_IN, go to BIAS.
- **BIAS:** one cycle. res = acc + sext(bias). If RELU_EN and res<0, res=0. Register res into out_data and go to OUT.
- **OUT:** out_valid_out=1 and out_data stays stable until out_ready_in. On the handshake, go to FIN.
- **FIN:** done=1 for one cycle, then go to IDLE.
- **Arithmetic:** two's complement throughout. Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation. The width rule on ACC_WIDTH makes wrap impossible for legal parameters.
- **Stored state:**
  - Weights and bias persist across jobs until a reload or rst.
  - out_data holds its last value after the job.

## Timing
- **Reset:** rst asserted at any time, including mid-load or mid-accumulate, forces IDLE asynchronously. It also:
  - drives all ready/valid/done outputs and out_data to 0;
  - clears w_loaded, acc, w_idx, ch_cnt, and the weight and bias registers.
- **Weight load:** one beat per cycle at full rate. A load takes CH_IN*K*K+1 cycles with continuous valid.
- **Windows:** one window per cycle at full rate; gaps in input_valid_in only stall.
- **Latency:** last window accepted at edge t → out_valid_out high after edge t+1 (BIAS at t, OUT from t+1).
- **Completion:** output handshake at edge h → done high in the cycle after h, IDLE after h+1.
- **Handshake rules:**
  - No ready output depends combinationally on its valid input.
  - Stalling upstream valid never drops data.
  - out_valid_out never deasserts before a handshake.
- **Minimum job latency with reused weights:** start edge → out_valid_out high after CH_IN+2 edges.

## Test plan
- **Basic accumulate:** K=3, CH_IN=2, all weights 1, bias 0; two windows of all 2 → out_data=36 with one done pulse.
- **ReLU clamp:** all weights −1, bias 3, windows of all 5 (raw −87). RELU_EN=1 → 0. RELU_EN=0 → −87 (0xFFFFFFA9).
- **Weight reuse:** job 1 loads weights; job 2 uses keep_weights=1 with windows of all 1 → weight_ready_out stays 0 and out_data=18. keep_weights=1 after rst → a full load is required.
- **Backpressure and stalls:**
  - Hold out_ready_in low for 5 cycles → out_valid_out stays high, out_data constant, done only after the handshake.
  - Random gaps in weight/input valid → same result as full-rate runs.
- **Reset mid-operation:** assert rst after 7 weight beats and again after 1 window → all outputs 0 and state IDLE. The next job with keep_weights=1 performs a full reload and produces a correct result.
- **Ignored start:** pulse start during IN and OUT → no restart and no extra done pulse; the result is unchanged.
